// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter: FSM state, access owner
// and wait-counter width.
package mem_arb_pkg;

  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing one memory access; done flags the last
// access cycle (count == 1).
module mem_wait_counter
  import mem_arb_pkg::*;
(
  input  logic              stage_clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WCNT_W-1:0] load_val_i,
  output logic              done_c_o
);

  logic [WCNT_W-1:0] cnt_q;

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WCNT_W'(1);
    end
  end

  assign done_c_o = (cnt_q == WCNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (LS): LS
// priority with an IF starvation guard, fixed-length accesses, flush drop.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                stage_clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_valid,
  input  logic                flush,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                if_stall,
  output logic                ls_stall
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  state_e                state_q;
  owner_e                owner_q;
  logic                  store_q;
  logic                  drop_q;
  logic [STARVE_W-1:0]   starve_q;
  logic [DATA_W-1:0]     if_rdata_q;
  logic [DATA_W-1:0]     ls_rdata_q;
  logic                  if_valid_q;
  logic                  ls_valid_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [BE_W-1:0]       mem_be_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;

  logic                  start_c;
  logic                  grant_ls_c;
  logic                  starved_c;
  logic                  drop_c;
  logic                  wait_done_c;
  logic [STARVE_W-1:0]   starve_inc_c;

  // IF is forced only when it is actually competing and LS has hit the cap.
  assign start_c      = (state_q == IDLE) && (if_req || ls_req);
  assign starved_c    = (starve_q == STARVE_W'(STARVE_MAX));
  assign grant_ls_c   = ls_req && !(if_req && starved_c);
  assign starve_inc_c = starved_c ? starve_q : starve_q + STARVE_W'(1);
  assign drop_c       = drop_q || flush;

  mem_wait_counter u_wait (
    .stage_clk  (stage_clk),
    .reset      (reset),
    .load_i     (start_c),
    .load_val_i (WCNT_W'(WAIT_CYCLES)),
    .done_c_o   (wait_done_c)
  );

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      store_q     <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q  <= ACC;
            mem_en_q <= 1'b1;
            if (grant_ls_c) begin
              owner_q     <= OWN_LS;
              store_q     <= ls_we;
              mem_we_q    <= ls_we;
              mem_be_q    <= ls_be;
              mem_addr_q  <= ls_addr;
              mem_wdata_q <= ls_wdata;
              starve_q    <= if_req ? starve_inc_c : '0;
            end else begin
              owner_q     <= OWN_IF;
              store_q     <= 1'b0;
              mem_be_q    <= '1;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              starve_q    <= '0;
            end
          end
        end
        ACC: begin
          if (owner_q == OWN_IF && flush) begin
            drop_q <= 1'b1;
          end
          // Last access cycle: mem_rdata is valid now.
          if (wait_done_c) begin
            state_q <= RESP;
            if (owner_q == OWN_LS) begin
              ls_valid_q <= 1'b1;
              if (!store_q) begin
                ls_rdata_q <= mem_rdata;
              end
            end else if (!drop_c) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          drop_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_valid  = ls_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_stall  = if_req && !if_valid_q;
  assign ls_stall  = ls_req && !ls_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between two requesters: the fetch stage (IF) and the load/store stage (LS).
- Sequences each access over a fixed number of wait cycles.
- Returns read data with a one-cycle valid pulse.
- Produces the stall signals that gate stage_ena of the fetch and memory stages.
- A taken branch or misprediction (take_new_pc) discards any in-flight fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, memory access length in cycles; legal values are 1 to 15.
- STARVE_MAX, 4, number of consecutive LS grants made while IF waits, after which IF is forced.

Ports:
- stage_clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_valid or flush.
- if_addr  in  ADDR_W  fetch address (pc).
- if_rdata  out  DATA_W  fetched instruction, registered; holds its value between pulses.
- if_valid  out  1  one-cycle pulse, if_rdata valid.
- ls_req  in  1  load/store request; held with the other ls_* inputs stable until ls_valid.
- ls_we  in  1  1 means store.
- ls_be  in  DATA_W/8  byte enables.
- ls_addr  in  ADDR_W  data address.
- ls_wdata  in  DATA_W  store data.
- ls_rdata  out  DATA_W  load data, registered; unchanged on stores.
- ls_valid  out  1  one-cycle completion pulse for loads and stores.
- flush  in  1  take_new_pc from the fetch unit.
- mem_en  out  1  memory strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid during the last ACC cycle.
- if_stall  out  1  if_req & ~if_valid (combinational); drives ~stage_ena of fetch.
- ls_stall  out  1  ls_req & ~ls_valid (combinational).

Behaviour:
- Reset:
  - Every registered output is 0: if_rdata, ls_rdata, if_valid, ls_valid, mem_en, mem_we, mem_be, mem_addr, mem_wdata.
  - State is IDLE, starve_cnt is 0, drop flag is 0.
  - Reset asserted mid-access aborts the access with no valid pulse.
- FSM states are IDLE, ACC and RESP.
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise grant one requester at the edge, latch its address, write data, byte enables and write enable into the mem_* registers, and move to ACC.
  - Grant priority is LS over IF.
  - Exception: IF wins if if_req & ls_req and starve_cnt == STARVE_MAX.
- ACC:
  - Lasts exactly WAIT_CYCLES cycles, counted by a down-counter.
  - mem_en = 1 only in the first ACC cycle. mem_we also only in the first ACC cycle, and only for stores.
  - mem_addr, mem_be and mem_wdata are held stable for the whole of ACC.
  - At the edge ending the last ACC cycle, mem_rdata is captured into if_rdata or ls_rdata (reads only); then move to RESP.
- RESP:
  - Exactly one cycle; the granted valid is 1; then move to IDLE.
  - Arbitration happens only in IDLE, so throughput is one access per WAIT_CYCLES+2 cycles.
- Latency: request seen in IDLE cycle 0 → mem_en in cycle 1 → valid in cycle WAIT_CYCLES+1.
- Starvation counter:
  - starve_cnt is incremented (saturating at STARVE_MAX) on each LS grant made while if_req = 1.
  - It is cleared on any IF grant, and on any LS grant made while if_req = 0.
- Flush:
  - flush = 1 in any ACC cycle of an IF access sets the drop flag.
  - The memory access still completes, but RESP gives if_valid = 0, if_rdata is not updated, and the drop flag is cleared.
  - flush in IDLE or in RESP, or during an LS access, has no effect.
  - The new if_addr is arbitrated normally in the following IDLE.
- Simultaneous if_req & ls_req in IDLE: resolved purely by priority and starve_cnt; the loser keeps its request and stall asserted.
- A requester dropping its req mid-access: the access completes and the valid pulse is still generated (except for the flush case).
- Widths: no arithmetic on addresses or data. The wait counter is 4 bits.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2;
  - owner encoding: OWN_IF = 1'b0, OWN_LS = 1'b1;
  - width localparam for the wait counter.
- One natural sub-module: mem_wait_counter, a loadable 4-bit down-counter with a done flag. Everything else stays in mem_port_arbiter.

Test Plan (WAIT_CYCLES=2, STARVE_MAX=2):
- Reset with random inputs → all outputs 0, if_stall = if_req; release reset, no requests → mem_en stays 0.
- IF read: if_req, if_addr=0x10 in cycle 0, memory returns 0x00500093 in cycle 2 → mem_en=1 with mem_addr=0x10 in cycle 1 only; if_valid=1 with if_rdata=0x00500093 in cycle 3; if_stall=1 in cycles 0-2, 0 in cycle 3.
- Simultaneous: if_req with addr 0x20, ls_req store with addr 0x100, wdata 0xDEADBEEF, be=4'hF → store first (mem_we=1 in cycle 1, ls_valid in cycle 3); IF mem_en in cycle 5, if_valid in cycle 7.
- Starvation: ls_req held continuously, if_req high → two LS accesses complete, third grant goes to IF, then starve_cnt=0 and LS resumes.
- Flush: IF access to 0x30, flush=1 in cycle 2 → no if_valid in cycle 3, if_rdata unchanged; new if_addr=0x80 → mem_addr=0x80 in cycle 5.
- Reset in cycle 2 of an LS load → no ls_valid, all outputs 0, next request restarts from IDLE with latency WAIT_CYCLES+1.
